// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared widths and owner tag for the two-requester adder
package adder_arbiter_pkg;

    localparam int ADD_W   = 16;
    localparam int REQ_CNT = 2;

    typedef enum logic {
        OWNER_0 = 1'b0,
        OWNER_1 = 1'b1
    } owner_t;

endpackage

// File: rtl/adder_arbiter_fa16.sv
// rtl/adder_arbiter_fa16.sv - 16-bit signed adder with carry-out and two's-complement overflow
module FullAdderSigned16bit
    import adder_arbiter_pkg::*;
(
    input  logic [ADD_W-1:0] A,
    input  logic [ADD_W-1:0] B,
    input  logic             Cin,
    output logic [ADD_W-1:0] S,
    output logic             Cout,
    output logic             Overflow
);

    logic [ADD_W:0] sum;

    assign sum      = {1'b0, A} + {1'b0, B} + {{ADD_W{1'b0}}, Cin};
    assign S        = sum[ADD_W-1:0];
    assign Cout     = sum[ADD_W];
    assign Overflow = (A[ADD_W-1] == B[ADD_W-1]) && (S[ADD_W-1] != A[ADD_W-1]);

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester arbiter in front of a two-stage shared adder; ADDER_ARB_RR_EN selects round-robin
module adder_arbiter
    import adder_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [ADD_W-1:0] A0,
    input  logic [ADD_W-1:0] B0,
    input  logic [ADD_W-1:0] A1,
    input  logic [ADD_W-1:0] B1,
    input  logic             Cin0,
    input  logic             Cin1,
    output logic             Ack0,
    output logic             Ack1,
    output logic             RespValid0,
    output logic             RespValid1,
    output logic [ADD_W-1:0] S,
    output logic             Cout,
    output logic             Overflow
);

    logic [REQ_CNT-1:0] req;
    logic [REQ_CNT-1:0] grant;
    logic               accept;
    owner_t             accept_owner;

    logic               s1_valid;
    owner_t             s1_owner;
    logic [ADD_W-1:0]   s1_a;
    logic [ADD_W-1:0]   s1_b;
    logic               s1_cin;

    logic [ADD_W-1:0]   add_s;
    logic               add_cout;
    logic               add_ovf;

    assign req = {Req1, Req0};

`ifdef ADDER_ARB_RR_EN
    owner_t last_grant;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant = '0;
        if (!rst) begin
            if (req == 2'b11)
                grant = (last_grant == OWNER_1) ? 2'b01 : 2'b10;
            else
                grant = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= OWNER_1;
        else if (grant[1])
            last_grant <= OWNER_1;
        else if (grant[0])
            last_grant <= OWNER_0;
    end
`else
    always_comb begin
        grant = '0;
        if (!rst)
            grant = req[0] ? 2'b01 : {req[1], 1'b0};
    end
`endif

    assign Ack0         = grant[0];
    assign Ack1         = grant[1];
    assign accept       = |grant;
    assign accept_owner = grant[1] ? OWNER_1 : OWNER_0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_owner <= accept_owner;
                s1_a     <= grant[1] ? A1   : A0;
                s1_b     <= grant[1] ? B1   : B0;
                s1_cin   <= grant[1] ? Cin1 : Cin0;
            end
        end
    end

    FullAdderSigned16bit u_add (
        .A        (s1_a),
        .B        (s1_b),
        .Cin      (s1_cin),
        .S        (add_s),
        .Cout     (add_cout),
        .Overflow (add_ovf)
    );

    // Result registers only load with a valid stage-1 entry so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            RespValid0 <= 1'b0;
            RespValid1 <= 1'b0;
            S          <= '0;
            Cout       <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            RespValid0 <= s1_valid && (s1_owner == OWNER_0);
            RespValid1 <= s1_valid && (s1_owner == OWNER_1);
            if (s1_valid) begin
                S        <= add_s;
                Cout     <= add_cout;
                Overflow <= add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter, both arbitration builds
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        Req0, Req1;
    logic [15:0] A0, B0, A1, B1;
    logic        Cin0, Cin1;
    logic        Ack0, Ack1;
    logic        RespValid0, RespValid1;
    logic [15:0] S;
    logic        Cout, Overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    adder_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .Req0       (Req0),
        .Req1       (Req1),
        .A0         (A0),
        .B0         (B0),
        .A1         (A1),
        .B1         (B1),
        .Cin0       (Cin0),
        .Cin1       (Cin1),
        .Ack0       (Ack0),
        .Ack1       (Ack1),
        .RespValid0 (RespValid0),
        .RespValid1 (RespValid1),
        .S          (S),
        .Cout       (Cout),
        .Overflow   (Overflow)
    );

    always #5 clk = ~clk;

    // Protocol monitor: requester 1 must hold its operands while pending.
    logic        p_req1 = 1'b0;
    logic        p_ack1 = 1'b0;
    logic [15:0] p_a1   = '0;
    logic [15:0] p_b1   = '0;
    logic        p_cin1 = 1'b0;
    int          proto_viol = 0;
    int          both_ack   = 0;

    always @(posedge clk) begin
        if (!rst && p_req1 && !p_ack1 && Req1 &&
            (A1 != p_a1 || B1 != p_b1 || Cin1 != p_cin1))
            proto_viol <= proto_viol + 1;
        if (Ack0 && Ack1)
            both_ack <= both_ack + 1;
        p_req1 <= Req1;
        p_ack1 <= Ack1;
        p_a1   <= A1;
        p_b1   <= B1;
        p_cin1 <= Cin1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic rv0, input logic rv1,
                              input logic [15:0] s, input logic c, input logic v);
        check({tag, "_rv0"}, RespValid0, rv0);
        check({tag, "_rv1"}, RespValid1, rv1);
        check({tag, "_s"},   S,          s);
        check({tag, "_cout"}, Cout,      c);
        check({tag, "_ovf"}, Overflow,   v);
    endtask

    int   exp_g [5];
    logic exp_v [5];

    initial begin
        rst  = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        Cin0 = 1'b0; Cin1 = 1'b0;
        tick();
        tick();

        // Reset state, and no grant while rst is high.
        check_resp("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        Req0 = 1'b1; Req1 = 1'b1;
        #1;
        check("reset_ack0", Ack0, 1'b0);
        check("reset_ack1", Ack1, 1'b0);
        Req0 = 1'b0; Req1 = 1'b0;
        rst = 1'b0;

        // Single request with positive overflow.
        Req0 = 1'b1; A0 = 16'h7FFF; B0 = 16'h0001; Cin0 = 1'b0;
        #1;
        check("single_ack0", Ack0, 1'b1);
        check("single_ack1", Ack1, 1'b0);
        tick();
        Req0 = 1'b0;
        check("single_lat_rv0", RespValid0, 1'b0);
        tick();
        check_resp("single", 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        tick();
        check_resp("single_hold", 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Carry-out without overflow on requester 1.
        Req1 = 1'b1; A1 = 16'hFFFF; B1 = 16'h0001; Cin1 = 1'b0;
        #1;
        check("carry_ack1", Ack1, 1'b1);
        tick();
        Req1 = 1'b0;
        tick();
        check_resp("carry", 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Carry-in contribution.
        Req0 = 1'b1; A0 = 16'h1234; B0 = 16'h0FF0; Cin0 = 1'b1;
        tick();
        Req0 = 1'b0;
        tick();
        check_resp("cin", 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);

        // Negative overflow.
        Req1 = 1'b1; A1 = 16'h8000; B1 = 16'hFFFF; Cin1 = 1'b0;
        tick();
        Req1 = 1'b0;
        tick();
        check_resp("negovf", 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Contention directly after reset.
        do_reset();
`ifdef ADDER_ARB_RR_EN
        exp_g = '{0, 1, 0, 1, 0};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        exp_g = '{0, 0, 0, 0, 1};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        A0 = 16'h0001; B0 = 16'h0002; Cin0 = 1'b0;
        A1 = 16'h0010; B1 = 16'h0020; Cin1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                Req0 = 1'b1; Req1 = 1'b1;
            end else if (i == 4) begin
                Req0 = 1'b0;
`ifdef ADDER_ARB_RR_EN
                Req1 = 1'b0;
`else
                Req1 = 1'b1;
`endif
            end else begin
                Req0 = 1'b0; Req1 = 1'b0;
            end
            #1;
            if (i < 5) begin
                check($sformatf("cont_ack0_%0d", i), Ack0, exp_v[i] && exp_g[i] == 0);
                check($sformatf("cont_ack1_%0d", i), Ack1, exp_v[i] && exp_g[i] == 1);
            end
            tick();
            if (i >= 1) begin
                check($sformatf("cont_rv0_%0d", i - 1), RespValid0, exp_v[i-1] && exp_g[i-1] == 0);
                check($sformatf("cont_rv1_%0d", i - 1), RespValid1, exp_v[i-1] && exp_g[i-1] == 1);
                if (exp_v[i-1])
                    check($sformatf("cont_s_%0d", i - 1), S, (exp_g[i-1] == 1) ? 16'h0030 : 16'h0003);
            end
        end
        check("ack_exclusive", both_ack, 0);

        // Reset mid-flight drops the operation.
        Req0 = 1'b1; A0 = 16'h8030; B0 = 16'h80E0; Cin0 = 1'b0;
        #1;
        check("midrst_ack0", Ack0, 1'b1);
        tick();
        Req0 = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        check_resp("midrst", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        check_resp("midrst_after", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Requester 1 loses, then changes operands while still pending.
        do_reset();
        check("stall_viol_before", proto_viol, 0);
        Req0 = 1'b1; A0 = 16'h0001; B0 = 16'h0001; Cin0 = 1'b0;
        Req1 = 1'b1; A1 = 16'h1111; B1 = 16'h0001; Cin1 = 1'b0;
        #1;
        check("stall_ack0", Ack0, 1'b1);
        check("stall_ack1", Ack1, 1'b0);
        tick();
        Req0 = 1'b0;
        A1   = 16'h2222;
        #1;
        check("stall_ack1_late", Ack1, 1'b1);
        tick();
        Req1 = 1'b0;
        check_resp("stall_r0", 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
        tick();
        check_resp("stall_r1", 1'b0, 1'b1, 16'h2223, 1'b0, 1'b0);
        check("stall_viol_after", proto_viol, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
